// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite subordinate with a bank of NUM_REGS 32-bit control registers.
// Write and read channels are independent. Byte strobes are honoured.
// Accesses at or beyond NUM_REGS*4 return SLVERR.
module axi4_lite_slave_regs #(
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]           regs [NUM_REGS];
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  // Select the held payload if one was latched earlier, otherwise the live bus.
  always_comb begin
    wr_addr     = aw_held ? awaddr_q : S_AXI_AWADDR;
    wr_data     = w_held ? wdata_q : S_AXI_WDATA;
    wr_strb     = w_held ? wstrb_q : S_AXI_WSTRB;
    wr_in_range = wr_addr < SPAN;
    wr_idx      = wr_addr[IDX_W+1:2];
    rd_in_range = S_AXI_ARADDR < SPAN;
    rd_idx      = S_AXI_ARADDR[IDX_W+1:2];
  end

  // Write channel: latch AW/W payloads independently, raise B on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          awaddr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= S_AXI_WDATA;
          wstrb_q <= S_AXI_WSTRB;
        end
        if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Register bank: byte-masked update and one-cycle write pulse on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && wr_in_range) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_idx == IDX_W'(k)) begin
            reg_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) regs[k][8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read channel: load R on AR handshake; same-edge writes are not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_in_range ? regs[rd_idx] : 32'h0;
      S_AXI_RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs with hand-computed expectations.
module tb_axi4_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [255:0] reg_out;
  logic [7:0]  reg_wr_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_r [8];

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.NUM_REGS(8), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_r%0d", tag, k), reg_out[32*k +: 32], exp_r[k]);
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
  endtask

  task automatic release_b();
    bready = 1'b1; step(); bready = 1'b0;
  endtask

  task automatic release_r();
    rready = 1'b1; step(); rready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) exp_r[k] = 32'h0;

    // Reset values
    #12;
    chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_awready", {31'h0, awready}, 32'h1);
    chk("rst_wready", {31'h0, wready}, 32'h1);
    chk("rst_arready", {31'h0, arready}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulse", {24'h0, reg_wr_pulse}, 32'h0);
    chk_regs("rst");
    @(negedge clk); rst = 1'b0;
    step();

    // Full write, same cycle AW/W
    issue_write(32'h04, 32'hDEADBEEF, 4'hF);
    exp_r[1] = 32'hDEADBEEF;
    chk("w1_bvalid", {31'h0, bvalid}, 32'h1);
    chk("w1_bresp", {30'h0, bresp}, 32'h0);
    chk("w1_pulse", {24'h0, reg_wr_pulse}, 32'h02);
    chk("w1_awready", {31'h0, awready}, 32'h0);
    chk_regs("w1");
    release_b();
    chk("w1_bclr", {31'h0, bvalid}, 32'h0);
    chk("w1_pulse_clr", {24'h0, reg_wr_pulse}, 32'h0);
    chk("w1_awready2", {31'h0, awready}, 32'h1);
    chk("w1_wready2", {31'h0, wready}, 32'h1);
    issue_read(32'h04);
    chk("r1_rvalid", {31'h0, rvalid}, 32'h1);
    chk("r1_rdata", rdata, 32'hDEADBEEF);
    chk("r1_rresp", {30'h0, rresp}, 32'h0);
    chk("r1_arready", {31'h0, arready}, 32'h0);
    release_r();
    chk("r1_rclr", {31'h0, rvalid}, 32'h0);

    // Strobe 0101 over zero
    issue_write(32'h08, 32'h11223344, 4'b0101);
    exp_r[2] = 32'h00220044;
    chk("w2_pulse", {24'h0, reg_wr_pulse}, 32'h04);
    chk_regs("w2");
    release_b();

    // Top byte only over existing value; low address bits ignored
    issue_write(32'h07, 32'hAABBCCDD, 4'b1000);
    exp_r[1] = 32'hAAADBEEF;
    chk("w3_pulse", {24'h0, reg_wr_pulse}, 32'h02);
    chk_regs("w3");
    release_b();

    // Zero strobe: no change, pulse anyway
    issue_write(32'h08, 32'hFFFFFFFF, 4'b0000);
    chk("w4_bresp", {30'h0, bresp}, 32'h0);
    chk("w4_pulse", {24'h0, reg_wr_pulse}, 32'h04);
    chk_regs("w4");
    release_b();

    // W three cycles before AW, then BREADY low five cycles
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("sp_wready", {31'h0, wready}, 32'h0);
    chk("sp_awready", {31'h0, awready}, 32'h1);
    chk("sp_bvalid0", {31'h0, bvalid}, 32'h0);
    step(); step();
    awaddr = 32'h0C; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    exp_r[3] = 32'hCAFEF00D;
    chk("sp_bvalid", {31'h0, bvalid}, 32'h1);
    chk("sp_pulse", {24'h0, reg_wr_pulse}, 32'h08);
    chk_regs("sp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sp_hold_bvalid%0d", i), {31'h0, bvalid}, 32'h1);
      chk($sformatf("sp_hold_awready%0d", i), {31'h0, awready}, 32'h0);
      chk($sformatf("sp_hold_wready%0d", i), {31'h0, wready}, 32'h0);
      chk($sformatf("sp_hold_pulse%0d", i), {24'h0, reg_wr_pulse}, 32'h0);
    end
    release_b();
    chk("sp_bclr", {31'h0, bvalid}, 32'h0);
    chk("sp_awready2", {31'h0, awready}, 32'h1);
    chk("sp_wready2", {31'h0, wready}, 32'h1);

    // Out of range write and read
    issue_write(32'h20, 32'h12345678, 4'hF);
    chk("oor_bvalid", {31'h0, bvalid}, 32'h1);
    chk("oor_bresp", {30'h0, bresp}, 32'h2);
    chk("oor_pulse", {24'h0, reg_wr_pulse}, 32'h0);
    chk_regs("oor");
    release_b();
    issue_read(32'h20);
    chk("oor_rdata", rdata, 32'h0);
    chk("oor_rresp", {30'h0, rresp}, 32'h2);
    release_r();

    // Read and write of reg 0 at the same edge
    awaddr = 32'h00; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h00; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_r[0] = 32'h5;
    chk("rw_rdata", rdata, 32'h0);
    chk("rw_rresp", {30'h0, rresp}, 32'h0);
    chk("rw_pulse", {24'h0, reg_wr_pulse}, 32'h01);
    chk_regs("rw");
    bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
    issue_read(32'h00);
    chk("rw_rdata2", rdata, 32'h5);
    release_r();

    // Reset while AW is held
    awaddr = 32'h10; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("rh_awready", {31'h0, awready}, 32'h0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) exp_r[k] = 32'h0;
    chk("rh_awready_rst", {31'h0, awready}, 32'h1);
    chk("rh_bvalid_rst", {31'h0, bvalid}, 32'h0);
    chk_regs("rh");
    @(negedge clk); rst = 1'b0;
    step();
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("rh_w_bvalid", {31'h0, bvalid}, 32'h0);
    chk("rh_w_pulse", {24'h0, reg_wr_pulse}, 32'h0);
    chk("rh_w_wready", {31'h0, wready}, 32'h0);
    chk("rh_w_awready", {31'h0, awready}, 32'h1);
    step(); step();
    chk("rh_w_bvalid2", {31'h0, bvalid}, 32'h0);
    chk_regs("rh_w");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite subordinate exposing a bank of NUM_REGS 32-bit read/write control registers. It is the responder counterpart of the team's AXI4-Lite master and sits at the end of the control bus. It drives register contents and per-register write strobes into the datapath blocks. Write and read channels run independently and support byte strobes; out-of-range accesses return SLVERR.

## Interface
- NUM_REGS, 8: number of 32-bit registers (1..256); byte offsets 0 .. NUM_REGS*4-1.
- ADDR_WIDTH, 32: AXI address width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit i covers WDATA[8i+7:8i].
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write data handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address handshake.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2  read data and response.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data handshake.
- reg_out  out  NUM_REGS*32  register contents; register k at [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse, bit k, on each successful write to register k.

## Operation
- Decode: offset = address; ADDR[1:0] ignored; index = ADDR>>2. Out of range when ADDR >= NUM_REGS*4.
- Write channel state: aw_held, w_held flags, captured AWADDR, WDATA and WSTRB, plus BVALID.
- AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID (combinational from registered state).
- AW and W are accepted in either order or in the same cycle; each payload is latched at its own handshake.
- Commit edge: the edge at which both AW and W are available (one held and the other handshaking, or both handshaking).
  - In range: bytes with WSTRB=1 are updated, others keep their value; BRESP=00; reg_wr_pulse[index]=1 for the following cycle only.
  - Out of range: no register changes, no pulse; BRESP=10.
  - WSTRB=0000 in range: no bytes change, BRESP=00, pulse still asserted.
- At the commit edge BVALID is set and aw_held and w_held are cleared. BVALID and BRESP hold stable until the BREADY edge, which clears BVALID.
- Read: ARREADY = !RVALID. On the AR handshake edge, RDATA is loaded with reg[index] and RRESP=00. Out of range: RDATA=0, RRESP=10. RVALID is set on the same edge.
- RVALID, RDATA and RRESP hold stable until the RREADY edge, which clears RVALID.
- Read and write to the same register at the same edge: RDATA returns the pre-write value.
- The block never depends on the master holding VALID beyond its handshake.

## Timing
- Reset (async, immediate): all registers 0, reg_wr_pulse 0, BVALID 0, RVALID 0, BRESP 00, RRESP 00, RDATA 0, flags clear.
- After reset, AWREADY, WREADY and ARREADY are 1.
- Reset mid-transaction: any pending write is discarded without being committed; any pending response is dropped.
- Write latency: AW+W handshake at edge N -> BVALID=1 and reg_out updated in cycle N+1. With BREADY=1 in cycle N+1, BVALID clears at edge N+1 and AWREADY/WREADY are 1 in cycle N+2. Maximum throughput is one write per 2 cycles.
- Split write: AW at edge N, W at edge N+3 -> commit at N+3; AWREADY=0 during cycles N+1..N+4.
- Read latency: AR at edge N -> RVALID in cycle N+1. Maximum throughput is one read per 2 cycles.
- Backpressure: with BREADY or RREADY held low, the response holds for any number of cycles and the corresponding READY stays 0.

## Test plan
- Write 0xDEADBEEF to 0x04 with WSTRB 1111, AW and W same cycle -> BVALID next cycle, BRESP 00, reg_out[63:32]=0xDEADBEEF, reg_wr_pulse=0x02 for one cycle. Read 0x04 -> RDATA 0xDEADBEEF, RRESP 00.
- Write 0x11223344 to 0x08 with WSTRB 0101, over a prior value of 0 -> reg 2 = 0x00220044.
- W handshake 3 cycles before AW, with BREADY held low for 5 cycles -> a single commit occurs; BVALID holds through the stall; AWREADY and WREADY stay 0 until BVALID clears.
- With NUM_REGS=8, write and read at 0x20 -> BRESP 10, no register changes, no pulse; RDATA 0, RRESP 10.
- Read of 0x00 in the same cycle as a committing write of 0x5 to 0x00 -> RDATA 0x0; a subsequent read returns 0x5.
- Assert rst while aw_held=1 -> all outputs return to reset values; a following W-only handshake produces no commit and no BVALID.
